// File: rtl/aes_decrypt_iter_if.sv
// Handshake bundle for aes_decrypt_iter.
//   in_valid/in_ready : ciphertext + key accept handshake
//   data_in, key      : 128-bit ciphertext and cipher key, [127:120] = byte 0
//   out_valid/out_ready : plaintext return handshake
//   data_out          : 128-bit plaintext
// master: the block feeding ciphertext and consuming plaintext.
// slave : the decryptor.
interface aes_decrypt_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_in;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] data_out;

  modport master (
    output in_valid, data_in, key, out_ready,
    input  in_ready, out_valid, data_out
  );

  modport slave (
    input  in_valid, data_in, key, out_ready,
    output in_ready, out_valid, data_out
  );
endinterface

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 decryptor (FIPS-197 inverse cipher).
// One ciphertext/key pair is accepted in IDLE, the key is expanded forward
// (10 cycles), the last round key is added, and ten inverse rounds run over a
// single shared datapath. The plaintext is held on data_out until out_ready.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : aes_decrypt_iter_if.slave (in_valid/in_ready/data_in/key,
//            out_valid/out_ready/data_out)
// Parameters:
//   NR      : round count, only 10 is legal
//   CLR_OUT : 1 forces data_out to zero while out_valid is low
// Optional feature macro: AES_DEC_KEY_CACHE_EN keeps the expanded round keys
// between jobs and skips key expansion when the same key arrives again.

// Inverse S-box: inverse affine transform followed by GF(2^8) inversion.
module inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] p, input logic [7:0] q);
    logic [7:0] acc, x;
    acc = 8'h00;
    x   = p;
    for (int i = 0; i < 8; i++) begin
      if (q[i]) acc = acc ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // x^254 is the multiplicative inverse; it also maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq, r;
    sq = x;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  assign y = gf_inv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
endmodule

module aes_decrypt_iter #(
  parameter int NR      = 10,
  parameter bit CLR_OUT = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  aes_decrypt_iter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, KEXP, ADDK, ROUND, DONE} state_t;

  state_t       state_q, state_d;
  logic [3:0]   rnd_q;
  logic [127:0] st_q;
  logic [127:0] res_q;
  logic [127:0] rk_q [0:10];
  logic         hit;
  logic [127:0] sr, sb, t, imc, rk_prev;
  logic [31:0]  rot, sub, temp, nw0, nw1, nw2, nw3;

  if (NR != 10) begin : g_nr_check
    $error("aes_decrypt_iter supports only NR=10 (AES-128)");
  end

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] p, input logic [7:0] q);
    logic [7:0] acc, x;
    acc = 8'h00;
    x   = p;
    for (int i = 0; i < 8; i++) begin
      if (q[i]) acc = acc ^ x;
      x = xt(x);
    end
    return acc;
  endfunction

  function automatic logic [7:0] fwd_sbox(input logic [7:0] a);
    logic [7:0] sq, r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r ^ rotl(r, 1) ^ rotl(r, 2) ^ rotl(r, 3) ^ rotl(r, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] c;
    case (r)
      4'd1:    c = 8'h01;
      4'd2:    c = 8'h02;
      4'd3:    c = 8'h04;
      4'd4:    c = 8'h08;
      4'd5:    c = 8'h10;
      4'd6:    c = 8'h20;
      4'd7:    c = 8'h40;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h1b;
      4'd10:   c = 8'h36;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  // Byte index is 4*column + row; row r is rotated right by r columns.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a, m2, m4, m8;
    logic [7:0]   m9 [4];
    logic [7:0]   mb [4];
    logic [7:0]   md [4];
    logic [7:0]   me [4];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) begin
        a     = s[127-8*(4*c+i) -: 8];
        m2    = xt(a);
        m4    = xt(m2);
        m8    = xt(m4);
        m9[i] = m8 ^ a;
        mb[i] = m8 ^ m2 ^ a;
        md[i] = m8 ^ m4 ^ a;
        me[i] = m8 ^ m4 ^ m2;
      end
      for (int i = 0; i < 4; i++)
        o[127-8*(4*c+i) -: 8] = me[i] ^ mb[(i+1)%4] ^ md[(i+2)%4] ^ m9[(i+3)%4];
    end
    return o;
  endfunction

  // Inverse round datapath; InvSubBytes and InvShiftRows commute.
  assign sr = inv_shift_rows(st_q);

  for (genvar i = 0; i < 16; i++) begin : g_isb
    inv_sbox u_isb (.a(sr[127-8*i -: 8]), .y(sb[127-8*i -: 8]));
  end

  assign t   = sb ^ rk_q[rnd_q];
  assign imc = inv_mix_columns(t);

  // Forward key schedule step producing rk[rnd] from rk[rnd-1].
  assign rk_prev = rk_q[rnd_q - 4'd1];
  assign rot     = {rk_prev[23:0], rk_prev[31:24]};
  assign sub     = {fwd_sbox(rot[31:24]), fwd_sbox(rot[23:16]),
                    fwd_sbox(rot[15:8]), fwd_sbox(rot[7:0])};
  assign temp    = sub ^ {rcon(rnd_q), 24'h0};
  assign nw0     = rk_prev[127:96] ^ temp;
  assign nw1     = rk_prev[95:64] ^ nw0;
  assign nw2     = rk_prev[63:32] ^ nw1;
  assign nw3     = rk_prev[31:0] ^ nw2;

`ifdef AES_DEC_KEY_CACHE_EN
  logic cache_vld_q;

  // rk_q only changes through a completed expansion, so once set the cached
  // schedule always belongs to rk_q[0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cache_vld_q <= 1'b0;
    else if (state_q == KEXP && rnd_q == 4'd10) cache_vld_q <= 1'b1;
  end

  assign hit = cache_vld_q && (bus.key == rk_q[0]);
`else
  assign hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.data_out  = CLR_OUT ? '0 : res_q;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_d = hit ? ADDK : KEXP;
      end
      KEXP:  if (rnd_q == 4'd10) state_d = ADDK;
      ADDK:  state_d = ROUND;
      ROUND: if (rnd_q == 4'd0) state_d = DONE;
      DONE: begin
        bus.out_valid = 1'b1;
        bus.data_out  = res_q;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rnd_q <= '0;
      st_q  <= '0;
      res_q <= '0;
      for (int i = 0; i <= 10; i++) rk_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          st_q    <= bus.data_in;
          rk_q[0] <= bus.key;
          rnd_q   <= 4'd1;
        end
        KEXP: begin
          rk_q[rnd_q] <= {nw0, nw1, nw2, nw3};
          rnd_q       <= rnd_q + 4'd1;
        end
        ADDK: begin
          st_q  <= st_q ^ rk_q[10];
          rnd_q <= 4'd9;
        end
        ROUND: begin
          if (rnd_q == 4'd0) begin
            st_q  <= t;
            res_q <= t;
          end else begin
            st_q  <= imc;
            rnd_q <= rnd_q - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_decrypt_iter.sv
module tb_aes_decrypt_iter;
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_decrypt_iter_if bif();
  aes_decrypt_iter dut (.clk(clk), .rst_n(rst_n), .bus(bif));

  typedef struct {
    logic [127:0] pt;
    int           acc;
    int           lat;
  } exp_t;

  exp_t         sbq[$];
  logic [7:0]   sbox [256];
  logic         cache_v = 1'b0;
  logic [127:0] cache_k = '0;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return (a << 1) ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // Walks the multiplicative group with generator 3 and its inverse in step,
  // filling the S-box table without any inversion arithmetic.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox[0] = 8'h63;
  endtask

  // Reference model: forward AES-128 encryption; the decryptor must invert it.
  function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [127:0] key);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   n [16];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [31:0]  tmp;
    logic [127:0] o;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]} ^ {rc, 24'h0};
        rc  = xtime(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int i = 0; i < 16; i++) n[i] = sbox[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          s[4*c+r] = n[4*((c+r)%4)+r];
      if (rd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
          s[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rd + i/4][31-8*(i%4) -: 8];
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic issue(input logic [127:0] ct, input logic [127:0] k,
                       input logic [127:0] pt, output int lat);
    int   n;
    exp_t e;
    n = 0;
    lat = 21;
    @(negedge clk);
    while (!bif.in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!bif.in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL issue_timeout: got in_ready=0 for %0d cycles, expected 1", n);
      return;
    end
    bif.in_valid = 1'b1;
    bif.data_in  = ct;
    bif.key      = k;
    @(posedge clk);
    #1;
`ifdef AES_DEC_KEY_CACHE_EN
    lat = (cache_v && k == cache_k) ? 11 : 21;
`else
    lat = 21;
`endif
    cache_v = 1'b1;
    cache_k = k;
    e.pt  = pt;
    e.acc = cyc;
    e.lat = lat;
    sbq.push_back(e);
    bif.in_valid = 1'b0;
    bif.data_in  = rnd128();
    bif.key      = rnd128();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sbq.size() != 0 || bif.out_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0 || bif.out_valid) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending jobs, expected 0", sbq.size());
    end
  endtask

  // Monitor: compares every new output against the oldest expected job.
  initial begin
    logic prev_v;
    exp_t e;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v = 1'b0;
      end else begin
        if (bif.out_valid && !prev_v) begin
          if (sbq.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_output: got data_out=%h, expected no output", bif.data_out);
          end else begin
            e = sbq.pop_front();
            chk("plaintext", bif.data_out, e.pt);
            chk_int("latency", cyc - e.acc, e.lat);
          end
        end
        prev_v = bif.out_valid;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of run, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int           lat, wait_n;
    logic [127:0] k, pt;
    build_sbox();
    bif.in_valid  = 1'b0;
    bif.data_in   = '0;
    bif.key       = '0;
    bif.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", 128'(bif.in_ready), 128'd1);
    chk("reset_out_valid", 128'(bif.out_valid), 128'd0);
    chk("reset_data_out", bif.data_out, 128'd0);

    // Known vectors, repeated key, input toggling after accept.
    issue(C1, K1, P1, lat);
    issue(C1, K1, P1, lat);
    issue(C2, K2, P2, lat);
    issue(C1, K1, P1, lat);
    drain();

    // Backpressure in DONE.
    bif.out_ready = 1'b0;
    issue(C2, K2, P2, lat);
    wait_n = 0;
    while (!bif.out_valid && wait_n < 100) begin
      @(negedge clk);
      wait_n++;
    end
    chk("bp_valid_seen", 128'(bif.out_valid), 128'd1);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 128'(bif.out_valid), 128'd1);
      chk("bp_data_out", bif.data_out, P2);
      chk("bp_in_ready", 128'(bif.in_ready), 128'd0);
    end
    bif.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", 128'(bif.in_ready), 128'd1);
    chk("bp_release_out_valid", 128'(bif.out_valid), 128'd0);
    chk("bp_release_data_out", bif.data_out, 128'd0);

    // Reset while ROUND is at rnd=5.
    issue(C2, K2, P2, lat);
    repeat (lat - 6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 128'(bif.out_valid), 128'd0);
    chk("midrst_data_out", bif.data_out, 128'd0);
    sbq.delete();
    cache_v = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 128'(bif.in_ready), 128'd1);
    chk("midrst_out_valid_after", 128'(bif.out_valid), 128'd0);
    issue(C1, K1, P1, lat);
    drain();

    // Random blocks; keys repeat about half the time.
    k = rnd128();
    for (int j = 0; j < 20; j++) begin
      if (j > 0 && $urandom_range(0, 1) == 0) k = rnd128();
      pt = rnd128();
      issue(encrypt(pt, k), k, pt, lat);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
